zuse_uart_host: RTL



---
 rtl/zuse_uart_host_if.sv | 30 +++
 rtl/zuse_uart_host.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zuse_uart_host_if.sv
// Request/response and uart byte-stream bundle of the tinyZuse FPU UART host.
interface zuse_uart_host_if;
  logic        start;
  logic [2:0]  op;
  logic [22:0] a;
  logic [22:0] b;
  logic [22:0] res;
  logic [2:0]  flags;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_busy;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [2:0]  dbg_state;

  // Handshakes: start is taken only on a cycle with busy=0 (busy is the inverse of ready);
  // done is a one-cycle valid qualifying res/flags/err; tx_en is a one-cycle strobe issued
  // only while tx_busy=0; rx_valid is a one-cycle strobe with no back-pressure.
  modport master (
    input  start, op, a, b, tx_busy, rx_data, rx_valid,
    output res, flags, busy, done, err, tx_data, tx_en, dbg_state
  );
  modport slave (
    output start, op, a, b, tx_busy, rx_data, rx_valid,
    input  res, flags, busy, done, err, tx_data, tx_en, dbg_state
  );
endinterface

// File: rtl/zuse_uart_host.sv
// Host-side initiator for the tinyZuse FPU UART protocol: sends operands and an op
// command, waits for the FPU, then reads back the result and status bytes.
module zuse_uart_host #(
  parameter int OP_WAIT_CYCLES = 64,
  parameter int RX_TIMEOUT     = 25000,
  parameter int TIMER_W        = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  zuse_uart_host_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_OPWAIT, S_SEND_RD, S_RECV_RS, S_SEND_ST, S_RECV_ST, S_DONE
  } state_t;

  typedef enum logic [1:0] {TX_ISSUE, TX_PULSE, TX_SETTLE, TX_DRAIN} tx_ph_t;

  localparam logic [7:0] CMD_SETR1    = 8'h82;
  localparam logic [7:0] CMD_SETR2    = 8'h83;
  localparam logic [7:0] CMD_OP_BASE  = 8'h88;
  localparam logic [7:0] CMD_READRS   = 8'h87;
  localparam logic [7:0] CMD_READSTAT = 8'h84;
  localparam logic [2:0] OP_SQRT      = 3'd4;
  localparam logic [3:0] IDX_OP       = 4'd8;
  localparam logic [TIMER_W-1:0] OPW_LAST  = TIMER_W'(OP_WAIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RXTO_LAST = TIMER_W'(RX_TIMEOUT - 1);

  state_t             state_q, state_d;
  tx_ph_t             tx_ph_q, tx_ph_d;
  logic [3:0]         idx_q, idx_d;
  logic [1:0]         rx_cnt_q, rx_cnt_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [2:0]         op_q, op_d;
  logic [22:0]        a_q, a_d;
  logic [22:0]        b_q, b_d;
  logic [15:0]        rs_buf_q, rs_buf_d;
  logic [22:0]        res_q, res_d;
  logic [2:0]         flags_q, flags_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_en_q, tx_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [7:0] seq_byte;
  logic [7:0] cur_byte;
  logic       op_bad;
  logic       tx_state;
  logic       tx_fin;

  // Byte index 0..3 is the SETR1 group, 4..7 the SETR2 group, 8 the op command.
  always_comb begin
    seq_byte = CMD_OP_BASE + {5'd0, op_q};
    case (idx_q)
      4'd0:    seq_byte = CMD_SETR1;
      4'd1:    seq_byte = a_q[22:15];
      4'd2:    seq_byte = a_q[14:7];
      4'd3:    seq_byte = {a_q[6:0], 1'b0};
      4'd4:    seq_byte = CMD_SETR2;
      4'd5:    seq_byte = b_q[22:15];
      4'd6:    seq_byte = b_q[14:7];
      4'd7:    seq_byte = {b_q[6:0], 1'b0};
      default: seq_byte = CMD_OP_BASE + {5'd0, op_q};
    endcase
  end

  always_comb begin
    cur_byte = seq_byte;
    if (state_q == S_SEND_RD) cur_byte = CMD_READRS;
    if (state_q == S_SEND_ST) cur_byte = CMD_READSTAT;
  end

  assign op_bad   = (op_q > OP_SQRT);
  assign tx_state = (state_q == S_SEND) || (state_q == S_SEND_RD) || (state_q == S_SEND_ST);
  assign tx_fin   = tx_state && (tx_ph_q == TX_DRAIN) && !bus.tx_busy;

  always_comb begin
    state_d   = state_q;
    tx_ph_d   = tx_ph_q;
    idx_d     = idx_q;
    rx_cnt_d  = rx_cnt_q;
    timer_d   = timer_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    rs_buf_d  = rs_buf_q;
    res_d     = res_q;
    flags_d   = flags_q;
    tx_data_d = tx_data_q;
    tx_en_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;

    // Byte engine: strobe when idle, skip the two cycles where tx_busy may still be
    // catching up, then wait for the transmitter to drain.
    if (tx_state && !(state_q == S_SEND && op_bad)) begin
      case (tx_ph_q)
        TX_ISSUE: begin
          if (!bus.tx_busy) begin
            tx_en_d   = 1'b1;
            tx_data_d = cur_byte;
            tx_ph_d   = TX_PULSE;
          end
        end
        TX_PULSE:  tx_ph_d = TX_SETTLE;
        TX_SETTLE: tx_ph_d = TX_DRAIN;
        default:   if (!bus.tx_busy) tx_ph_d = TX_ISSUE;
      endcase
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          a_d     = bus.a;
          b_d     = bus.b;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          idx_d   = '0;
          tx_ph_d = TX_ISSUE;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (op_bad) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else if (tx_fin) begin
          if (idx_q == IDX_OP) begin
            state_d = S_OPWAIT;
            timer_d = '0;
          end else if (idx_q == 4'd3 && op_q == OP_SQRT) begin
            idx_d = IDX_OP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_OPWAIT: begin
        if (timer_q == OPW_LAST) state_d = S_SEND_RD;
        else                     timer_d = timer_q + TIMER_W'(1);
      end
      S_SEND_RD: begin
        if (tx_fin) begin
          state_d  = S_RECV_RS;
          timer_d  = '0;
          rx_cnt_d = '0;
        end
      end
      S_RECV_RS: begin
        if (bus.rx_valid) begin
          timer_d  = '0;
          rx_cnt_d = rx_cnt_q + 2'd1;
          if (rx_cnt_q == 2'd0)      rs_buf_d[15:8] = bus.rx_data;
          else if (rx_cnt_q == 2'd1) rs_buf_d[7:0]  = bus.rx_data;
          else begin
            res_d   = {rs_buf_q, bus.rx_data[7:1]};
            state_d = S_SEND_ST;
          end
        end else if (timer_q == RXTO_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_SEND_ST: begin
        if (tx_fin) begin
          state_d = S_RECV_ST;
          timer_d = '0;
        end
      end
      S_RECV_ST: begin
        if (bus.rx_valid) begin
          flags_d = bus.rx_data[2:0];
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (timer_q == RXTO_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tx_ph_q   <= TX_ISSUE;
      idx_q     <= '0;
      rx_cnt_q  <= '0;
      timer_q   <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rs_buf_q  <= '0;
      res_q     <= '0;
      flags_q   <= '0;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_ph_q   <= tx_ph_d;
      idx_q     <= idx_d;
      rx_cnt_q  <= rx_cnt_d;
      timer_q   <= timer_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rs_buf_q  <= rs_buf_d;
      res_q     <= res_d;
      flags_q   <= flags_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.res       = res_q;
  assign bus.flags     = flags_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_en     = tx_en_q;
  assign bus.dbg_state = state_q;

endmodule
